instruction_fetch_unit: RTL

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/fetch_pkg.sv | 12 +
 rtl/if_skid_buffer.sv | 25 ++
 rtl/instruction_fetch_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the instruction fetch unit.
package fetch_pkg;
  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    KILL,
    FULL
  } state_e;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] PC_INC = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/if_skid_buffer.sv
// if_skid_buffer: one-entry {pc, instr} holding register for fetches that land while IF/ID is stalled.
module if_skid_buffer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        unload_i,
  input  logic        flush_i,
  input  logic [63:0] data_i,
  output logic        valid_o,
  output logic [63:0] data_o
);
  logic        valid_q;
  logic [63:0] data_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= !flush_i && (load_i || (valid_q && !unload_i));
      if (load_i) data_q <= data_i;
    end
  end
  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: IF stage with one request in flight, redirect/kill handling and a skid entry.
// Define IFU_MISALIGN_CHECK_EN to word-align redirect targets and flag misaligned ones.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        PC_SEL,
  input  logic [31:0] BRANCH_TARGET,
  input  logic        STALL,
  output logic [31:0] IMEM_ADDRESS,
  output logic        IMEM_READ,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSYWAIT,
  output logic [31:0] OUT_PC,
  output logic [31:0] OUT_INSTRUCTION,
  output logic        OUT_VALID,
  output logic        BUSYWAIT,
  output logic        MISALIGN_FAULT
);
  state_e      state_q;
  logic [31:0] pc_q, addr_q, out_pc_q, out_instr_q, target;
  logic        out_valid_q, done, consume;
  logic        skid_valid, skid_load, skid_unload;
  logic [63:0] skid_data;
  assign IMEM_READ   = (state_q == FETCH) || (state_q == KILL);
  assign done        = IMEM_READ && !IMEM_BUSYWAIT;
  assign consume     = out_valid_q && !STALL;
  assign skid_load   = !PC_SEL && (state_q == FETCH) && done && out_valid_q && STALL;
  assign skid_unload = !PC_SEL && skid_valid && !STALL;
`ifdef IFU_MISALIGN_CHECK_EN
  logic fault_q;
  assign target = {BRANCH_TARGET[31:2], 2'b00};
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) fault_q <= 1'b0;
    else if (PC_SEL && BRANCH_TARGET[1:0] != 2'b00) fault_q <= 1'b1;
  end
  assign MISALIGN_FAULT = fault_q;
`else
  assign target = BRANCH_TARGET;
  assign MISALIGN_FAULT = 1'b0;
`endif
  if_skid_buffer u_skid (
    .clk_i   (CLK),
    .rst_ni  (RESET),
    .load_i  (skid_load),
    .unload_i(skid_unload),
    .flush_i (PC_SEL),
    .data_i  ({addr_q, IMEM_READDATA}),
    .valid_o (skid_valid),
    .data_o  (skid_data)
  );
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      out_pc_q    <= '0;
      out_instr_q <= NOP;
      out_valid_q <= 1'b0;
    end else if (PC_SEL) begin
      out_valid_q <= 1'b0;
      // An outstanding read must drain on its old address before the target can be issued
      if (IMEM_READ && IMEM_BUSYWAIT) begin
        state_q <= KILL;
        pc_q    <= target;
      end else begin
        state_q <= FETCH;
        addr_q  <= target;
        pc_q    <= target + PC_INC;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= FETCH;
          addr_q  <= pc_q;
          pc_q    <= pc_q + PC_INC;
        end
        FETCH: begin
          if (done && (!out_valid_q || !STALL)) begin
            out_pc_q    <= addr_q;
            out_instr_q <= IMEM_READDATA;
            out_valid_q <= 1'b1;
            addr_q      <= pc_q;
            pc_q        <= pc_q + PC_INC;
          end else if (done) begin
            state_q <= FULL;
          end else if (consume) begin
            out_valid_q <= 1'b0;
          end
        end
        KILL: begin
          if (consume) out_valid_q <= 1'b0;
          if (done) begin
            state_q <= FETCH;
            addr_q  <= pc_q;
            pc_q    <= pc_q + PC_INC;
          end
        end
        FULL: begin
          if (skid_unload) begin
            out_pc_q    <= skid_data[63:32];
            out_instr_q <= skid_data[31:0];
            state_q     <= FETCH;
            addr_q      <= pc_q;
            pc_q        <= pc_q + PC_INC;
          end
        end
      endcase
    end
  end
  assign IMEM_ADDRESS    = addr_q;
  assign OUT_PC          = out_pc_q;
  assign OUT_INSTRUCTION = out_instr_q;
  assign OUT_VALID       = out_valid_q;
  assign BUSYWAIT        = !out_valid_q;
endmodule
